// File: rtl/decryption_dispatcher.sv
// Purpose: front-end controller that routes one message to a selected decryption engine and muxes its output back.
// Latency: forwarding to the engine and the output mux are each 1 cycle, registered.
// Backpressure: busy_o is high from the cycle after the token until the engine drops busy; input is ignored meanwhile.
module decryption_dispatcher #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                 START_TIMEOUT          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           sel_i,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  output logic                 busy_o,
  output logic [3*D_WIDTH-1:0] eng_data_o,
  output logic [2:0]           eng_valid_o,
  input  logic [2:0]           eng_busy_i,
  input  logic [3*D_WIDTH-1:0] eng_data_i,
  input  logic [2:0]           eng_valid_i,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FWD, S_DISCARD, S_WAIT_START, S_WAIT_DONE
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(MAX_NOF_CHARS);
  localparam logic [7:0] TMO_MAX = 8'(START_TIMEOUT - 1);

  state_t state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           tmo_q, tmo_d;
  logic                 ovf_q, ovf_d;
  logic [3*D_WIDTH-1:0] eng_data_q, eng_data_d;
  logic [2:0]           eng_valid_q, eng_valid_d;
  logic [D_WIDTH-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;

  logic                 tok_v, chr_v;
  logic                 fwd_en;
  logic [1:0]           route;
  logic                 busy_sel, vld_sel;
  logic [D_WIDTH-1:0]   dat_sel;

  assign tok_v = valid_i && (data_i == START_DECRYPTION_TOKEN);
  assign chr_v = valid_i && (data_i != START_DECRYPTION_TOKEN);

  // Selected engine's status/data; sel_q==3 never reaches the wait states, but keep it defined
  always_comb begin
    busy_sel = 1'b0;
    vld_sel  = 1'b0;
    dat_sel  = '0;
    case (sel_q)
      2'd0: begin busy_sel = eng_busy_i[0]; vld_sel = eng_valid_i[0]; dat_sel = eng_data_i[0*D_WIDTH +: D_WIDTH]; end
      2'd1: begin busy_sel = eng_busy_i[1]; vld_sel = eng_valid_i[1]; dat_sel = eng_data_i[1*D_WIDTH +: D_WIDTH]; end
      2'd2: begin busy_sel = eng_busy_i[2]; vld_sel = eng_valid_i[2]; dat_sel = eng_data_i[2*D_WIDTH +: D_WIDTH]; end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; engine busy wins over a timeout landing on the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (chr_v) state_d = (sel_i == 2'd3) ? S_DISCARD : S_FWD;
      S_FWD:        if (tok_v) state_d = S_WAIT_START;
      S_DISCARD:    if (tok_v) state_d = S_IDLE;
      S_WAIT_START: if (busy_sel) state_d = S_WAIT_DONE;
                    else if (tmo_q >= TMO_MAX) state_d = S_IDLE;
      S_WAIT_DONE:  if (!busy_sel) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Datapath and status outputs for the current state
  always_comb begin
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    ovf_d       = ovf_q;
    fwd_en      = 1'b0;
    route       = sel_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    eng_data_d  = '0;
    eng_valid_d = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tmo_d = '0;
        ovf_d = 1'b0;
        if (chr_v) begin
          sel_d = sel_i;
          if (sel_i == 2'd3) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else begin
            fwd_en = 1'b1;
            route  = sel_i;
            cnt_d  = 8'd1;
          end
        end else if (tok_v) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
        end
      end
      S_FWD: begin
        if (tok_v) begin
          fwd_en = 1'b1;
        end else if (chr_v) begin
          if (cnt_q < CNT_MAX) begin
            fwd_en = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end else if (!ovf_q) begin
            ovf_d      = 1'b1;
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end
        end
      end
      S_WAIT_START: begin
        data_d  = dat_sel;
        valid_d = vld_sel;
        if (!busy_sel) begin
          if (tmo_q >= TMO_MAX) begin
            err_d      = 1'b1;
            err_code_d = 2'd3;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
      end
      S_WAIT_DONE: begin
        data_d  = dat_sel;
        valid_d = vld_sel;
      end
      default: ;
    endcase
    // Only the routed slice ever carries data, so no other engine can see the token
    for (int k = 0; k < 3; k++) begin
      if (fwd_en && (route == 2'(k))) begin
        eng_data_d[k*D_WIDTH +: D_WIDTH] = data_i;
        eng_valid_d[k]                   = 1'b1;
      end
    end
    busy_d = (state_d == S_WAIT_START) || (state_d == S_WAIT_DONE);
  end

  // Registered datapath, counters and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      ovf_q       <= 1'b0;
      eng_data_q  <= '0;
      eng_valid_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      ovf_q       <= ovf_d;
      eng_data_q  <= eng_data_d;
      eng_valid_q <= eng_valid_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign busy_o      = busy_q;
  assign eng_data_o  = eng_data_q;
  assign eng_valid_o = eng_valid_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_decryption_dispatcher.sv
// Scoreboard bench for decryption_dispatcher: directed messages, engine model, async reset.
module tb_decryption_dispatcher;
  localparam logic [7:0] TOK = 8'hFA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel_i = '0;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        busy_o;
  logic [23:0] eng_data_o;
  logic [2:0]  eng_valid_o;
  logic [2:0]  eng_busy_i = '0;
  logic [23:0] eng_data_i = '0;
  logic [2:0]  eng_valid_i = '0;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  decryption_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .sel_i(sel_i), .data_i(data_i), .valid_i(valid_i),
    .busy_o(busy_o), .eng_data_o(eng_data_o), .eng_valid_o(eng_valid_o),
    .eng_busy_i(eng_busy_i), .eng_data_i(eng_data_i), .eng_valid_i(eng_valid_i),
    .data_o(data_o), .valid_o(valid_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] slice;
    logic [7:0] dat;
  } fwd_t;

  fwd_t       fwd_q[$];
  logic [7:0] out_q[$];
  logic [1:0] errc_q[$];
  int checks = 0;
  int errors = 0;
  fwd_t       mon_f;
  logic [7:0] mon_d;
  logic [1:0] mon_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_fwd(input logic [1:0] s, input logic [7:0] d);
    fwd_t e;
    e.slice = s;
    e.dat   = d;
    fwd_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] s, input logic [7:0] d);
    @(posedge clk); #1;
    sel_i = s; data_i = d; valid_i = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare whenever the DUT presents something
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_valid_o != 3'b000) begin
        if (fwd_q.size() == 0) check("unexpected_eng_valid", 32'(eng_valid_o), 32'h0);
        else begin
          mon_f = fwd_q.pop_front();
          check("eng_valid_o", 32'(eng_valid_o), 32'(3'b001 << mon_f.slice));
          check("eng_data_o", 32'(eng_data_o), 32'(mon_f.dat) << (8 * mon_f.slice));
        end
      end
      if (valid_o) begin
        if (out_q.size() == 0) check("unexpected_valid_o", 32'(valid_o), 32'h0);
        else begin
          mon_d = out_q.pop_front();
          check("data_o", 32'(data_o), 32'(mon_d));
        end
      end
      if (err_o) begin
        if (errc_q.size() == 0) check("unexpected_err_o", 32'(err_o), 32'h0);
        else begin
          mon_c = errc_q.pop_front();
          check("err_code_o", 32'(err_code_o), 32'(mon_c));
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_busy", 32'(busy_o), 0);
    check("rst_eng_valid", 32'(eng_valid_o), 0);
    check("rst_err_code", 32'(err_code_o), 0);
    #10 rst_n = 1'b1;

    // 1+2: sel=1 "ABCDEF" + token, then engine 1 returns six chars
    for (int i = 0; i < 6; i++) begin
      send(2'd1, 8'h41 + 8'(i));
      push_fwd(2'd1, 8'h41 + 8'(i));
    end
    send(2'd1, TOK);
    push_fwd(2'd1, TOK);
    check("busy_before_token_taken", 32'(busy_o), 0);
    idle();
    check("busy_after_token", 32'(busy_o), 1);
    @(posedge clk); #1;
    eng_busy_i = 3'b010;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      valid_i = (i == 0);
      sel_i = 2'd2; data_i = 8'h77;
      eng_valid_i = 3'b010;
      eng_data_i = {8'h00, 8'h61 + 8'(i), 8'h00};
      out_q.push_back(8'h61 + 8'(i));
    end
    @(posedge clk); #1;
    eng_valid_i = '0; eng_busy_i = '0;
    check("busy_held_while_engine_busy", 32'(busy_o), 1);
    @(posedge clk); #1;
    check("busy_fell", 32'(busy_o), 0);
    wait_cyc(2);

    // Empty message: lone token in IDLE
    send(2'd0, TOK);
    errc_q.push_back(2'd2);
    idle();
    wait_cyc(2);

    // 3: sel=3 discards the message
    send(2'd3, 8'h41);
    errc_q.push_back(2'd1);
    send(2'd3, 8'h42);
    send(2'd3, TOK);
    idle();
    check("busy_after_discard", 32'(busy_o), 0);
    wait_cyc(2);

    // 4: sel=0, 52 chars (sel_i wiggles after the first), then token; engine never starts
    for (int i = 0; i < 52; i++) begin
      send((i == 0) ? 2'd0 : 2'(i % 4), 8'h20 + 8'(i));
      if (i < 50) push_fwd(2'd0, 8'h20 + 8'(i));
      if (i == 50) errc_q.push_back(2'd2);
    end
    send(2'd1, TOK);
    push_fwd(2'd0, TOK);
    idle();
    errc_q.push_back(2'd3);
    wait_cyc(20);

    // 5: sel=2, engine never busy -> timeout exactly 16 cycles into WAIT_START
    send(2'd2, 8'h58); push_fwd(2'd2, 8'h58);
    send(2'd2, 8'h59); push_fwd(2'd2, 8'h59);
    send(2'd2, TOK);   push_fwd(2'd2, TOK);
    idle();
    check("busy_wait_start", 32'(busy_o), 1);
    errc_q.push_back(2'd3);
    wait_cyc(15);
    check("no_early_timeout", 32'(err_o), 0);
    wait_cyc(1);
    check("timeout_err", 32'(err_o), 1);
    check("timeout_code", 32'(err_code_o), 3);
    check("busy_after_timeout", 32'(busy_o), 0);
    wait_cyc(2);

    // 6: asynchronous reset in WAIT_DONE, then a fresh message
    send(2'd0, 8'h51); push_fwd(2'd0, 8'h51);
    send(2'd0, TOK);   push_fwd(2'd0, TOK);
    idle();
    eng_busy_i = 3'b001;
    @(posedge clk); #1;
    eng_valid_i = 3'b001; eng_data_i = 24'h000055;
    out_q.push_back(8'h55);
    @(posedge clk); #1;
    eng_valid_i = '0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 0);
    check("arst_valid_o", 32'(valid_o), 0);
    check("arst_data_o", 32'(data_o), 0);
    check("arst_err_code", 32'(err_code_o), 0);
    check("arst_eng_valid", 32'(eng_valid_o), 0);
    check("arst_eng_data", 32'(eng_data_o), 0);
    eng_busy_i = '0; eng_data_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd0, 8'h5A); push_fwd(2'd0, 8'h5A);
    send(2'd0, TOK);   push_fwd(2'd0, TOK);
    idle();
    check("busy_after_reset_msg", 32'(busy_o), 1);
    @(posedge clk); #1;
    eng_busy_i = 3'b001;
    @(posedge clk); #1;
    eng_busy_i = 3'b000;
    wait_cyc(2);
    check("busy_idle_end", 32'(busy_o), 0);

    wait_cyc(3);
    check("fwd_queue_drained", 32'(fwd_q.size()), 0);
    check("out_queue_drained", 32'(out_q.size()), 0);
    check("err_queue_drained", 32'(errc_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
